// File: rtl/eth_sw_pkg.sv
// Shared types and default constants for the eth_switch store-and-forward datapath.
package eth_sw_pkg;
  localparam int DATA_W        = 64;
  localparam int FIFO_DEPTH    = 64;
  localparam int MAX_PKT_WORDS = 190;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
  } eth_word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } in_state_t;
endpackage

// File: rtl/eth_sw_fifo.sv
// Packet FIFO with a speculative write pointer: words become readable only once
// committed, and an uncommitted partial packet can be rolled back.
module eth_sw_fifo
  import eth_sw_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         wrEn,
  input  logic [$bits(eth_word_t)-1:0] wrWord,
  input  logic                         commit,
  input  logic                         rollback,
  input  logic                         rdEn,
  output logic [$bits(eth_word_t)-1:0] rdWord,
  output logic [$clog2(DEPTH):0]       usedWr,
  output logic [$clog2(DEPTH):0]       usedCmt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  eth_word_t   mem [DEPTH];
  logic [AW:0] wrPtr_r;
  logic [AW:0] cmtPtr_r;
  logic [AW:0] rdPtr_r;
  logic [AW:0] base_s;

  // A rollback in the same cycle as a write restarts the packet at the commit point.
  assign base_s  = rollback ? cmtPtr_r : wrPtr_r;
  assign rdWord  = mem[rdPtr_r[AW-1:0]];
  assign usedWr  = wrPtr_r - rdPtr_r;
  assign usedCmt = cmtPtr_r - rdPtr_r;

  // Storage array write port
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[base_s[AW-1:0]] <= eth_word_t'(wrWord);
    end
  end

  // Write, commit and read pointers
  always_ff @(posedge clk) begin
    if (resetN) begin
      wrPtr_r  <= '0;
      cmtPtr_r <= '0;
      rdPtr_r  <= '0;
    end else begin
      wrPtr_r <= wrEn ? base_s + PTR_ONE : base_s;
      if (commit) begin
        cmtPtr_r <= base_s + PTR_ONE;
      end
      if (rdEn) begin
        rdPtr_r <= rdPtr_r + PTR_ONE;
      end
    end
  end
endmodule

// File: rtl/eth_switch.sv
// Port-A store-and-forward switch datapath: framing FSM in front of a commit/rollback FIFO.
// Optional ETH_SW_STATS_EN adds packet in/out/drop counters.
module eth_switch
  import eth_sw_pkg::*;
#(
  parameter int DATA_W        = eth_sw_pkg::DATA_W,
  parameter int FIFO_DEPTH    = eth_sw_pkg::FIFO_DEPTH,
  parameter int MAX_PKT_WORDS = eth_sw_pkg::MAX_PKT_WORDS
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [DATA_W-1:0] inDataA,
  input  logic              inSopA,
  input  logic              inEopA,
  input  logic              vld,
  output logic [DATA_W-1:0] outDataA,
  output logic              outSopA,
  output logic              outEopA,
  output logic              outvld
`ifdef ETH_SW_STATS_EN
  ,
  output logic [31:0]       pkt_in_cnt,
  output logic [31:0]       pkt_out_cnt,
  output logic [31:0]       pkt_drop_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MAX_PKT_WORDS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_PKT_WORDS);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);

  in_state_t     state_r;
  in_state_t     nextState_s;
  logic [CW-1:0] pktWords_r;
  logic          wrEn_s;
  logic          commit_s;
  logic          rollback_s;
  logic          dropEvt_s;
  logic          rdEn_s;
  logic          fullWr_s;
  logic          fullCmt_s;
  logic          overflow_s;
  logic [AW:0]   usedWr_s;
  logic [AW:0]   usedCmt_s;
  eth_word_t     wrWord_s;
  eth_word_t     rdWord_s;

  assign wrWord_s   = '{data: 64'(inDataA), sop: inSopA, eop: inEopA};
  assign fullWr_s   = (usedWr_s == FULL_LVL);
  assign fullCmt_s  = (usedCmt_s == FULL_LVL);
  assign overflow_s = (pktWords_r == CNT_MAX) || fullWr_s;
  assign rdEn_s     = (usedCmt_s != '0);

  eth_sw_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .resetN  (resetN),
    .wrEn    (wrEn_s),
    .wrWord  (wrWord_s),
    .commit  (commit_s),
    .rollback(rollback_s),
    .rdEn    (rdEn_s),
    .rdWord  (rdWord_s),
    .usedWr  (usedWr_s),
    .usedCmt (usedCmt_s)
  );

  // Input FSM state register
  always_ff @(posedge clk) begin
    if (resetN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Input FSM next state; a sop always restarts framing regardless of state
  always_comb begin
    nextState_s = state_r;
    if (vld && inSopA) begin
      nextState_s = fullCmt_s ? ST_DROP : (inEopA ? ST_IDLE : ST_PKT);
    end else if (vld) begin
      case (state_r)
        ST_IDLE: nextState_s = ST_IDLE;
        ST_PKT:  nextState_s = overflow_s ? ST_DROP : (inEopA ? ST_IDLE : ST_PKT);
        ST_DROP: nextState_s = inEopA ? ST_IDLE : ST_DROP;
        default: nextState_s = ST_IDLE;
      endcase
    end else begin
      nextState_s = state_r;
    end
  end

  // Input FSM outputs: FIFO write/commit/rollback and drop events
  always_comb begin
    wrEn_s     = 1'b0;
    commit_s   = 1'b0;
    rollback_s = 1'b0;
    dropEvt_s  = 1'b0;
    if (vld && inSopA) begin
      rollback_s = 1'b1;
      if (fullCmt_s) begin
        dropEvt_s = 1'b1;
      end else begin
        wrEn_s    = 1'b1;
        commit_s  = inEopA;
        dropEvt_s = (state_r == ST_PKT);
      end
    end else if (vld) begin
      case (state_r)
        ST_IDLE: dropEvt_s = 1'b1;
        ST_PKT: begin
          if (overflow_s) begin
            rollback_s = 1'b1;
            dropEvt_s  = 1'b1;
          end else begin
            wrEn_s   = 1'b1;
            commit_s = inEopA;
          end
        end
        ST_DROP: dropEvt_s = 1'b0;
        default: dropEvt_s = 1'b0;
      endcase
    end else begin
      wrEn_s = 1'b0;
    end
  end

  // Word count of the packet being written
  always_ff @(posedge clk) begin
    if (resetN) begin
      pktWords_r <= '0;
    end else if (wrEn_s) begin
      pktWords_r <= inSopA ? CNT_ONE : pktWords_r + CNT_ONE;
    end
  end

  // Output engine: drain committed words back-to-back into registered outputs
  always_ff @(posedge clk) begin
    if (resetN) begin
      outvld   <= 1'b0;
      outSopA  <= 1'b0;
      outEopA  <= 1'b0;
      outDataA <= '0;
    end else begin
      outvld   <= rdEn_s;
      outSopA  <= rdEn_s & rdWord_s.sop;
      outEopA  <= rdEn_s & rdWord_s.eop;
      outDataA <= rdEn_s ? DATA_W'(rdWord_s.data) : '0;
    end
  end

`ifdef ETH_SW_STATS_EN
  // Wrapping packet statistics
  always_ff @(posedge clk) begin
    if (resetN) begin
      pkt_in_cnt   <= 32'd0;
      pkt_out_cnt  <= 32'd0;
      pkt_drop_cnt <= 32'd0;
    end else begin
      pkt_in_cnt   <= pkt_in_cnt + {31'd0, vld & inSopA};
      pkt_out_cnt  <= pkt_out_cnt + {31'd0, outvld & outEopA};
      pkt_drop_cnt <= pkt_drop_cnt + {31'd0, dropEvt_s};
    end
  end
`endif
endmodule

// File: tb/tb_eth_switch.sv
// Self-checking bench for eth_switch: latency vector table, directed corner
// sequences and a randomized packet stream against a packet-level model.
module tb_eth_switch;
  logic        clk = 1'b0;
  logic        resetN;
  logic [63:0] inDataA;
  logic        inSopA;
  logic        inEopA;
  logic        vld;
  logic [63:0] outDataA;
  logic        outSopA;
  logic        outEopA;
  logic        outvld;
`ifdef ETH_SW_STATS_EN
  logic [31:0] pkt_in_cnt;
  logic [31:0] pkt_out_cnt;
  logic [31:0] pkt_drop_cnt;
  logic [31:0] dropBase;
`endif

  eth_switch dut (
    .clk     (clk),
    .resetN  (resetN),
    .inDataA (inDataA),
    .inSopA  (inSopA),
    .inEopA  (inEopA),
    .vld     (vld),
    .outDataA(outDataA),
    .outSopA (outSopA),
    .outEopA (outEopA),
    .outvld  (outvld)
`ifdef ETH_SW_STATS_EN
    ,
    .pkt_in_cnt  (pkt_in_cnt),
    .pkt_out_cnt (pkt_out_cnt),
    .pkt_drop_cnt(pkt_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        s;
    logic        e;
    logic [63:0] d;
  } ow_t;

  typedef struct {
    logic        v;
    logic        s;
    logic        e;
    logic [63:0] d;
    logic [66:0] exp;
  } vec_t;

  ow_t  expQ[$];
  ow_t  cur[$];
  ow_t  monExp;
  vec_t tbl[12];
  int   nChecks = 0;
  int   nFails = 0;
  bit   monOn = 1'b0;
  bit   modelOn = 1'b0;
  bit   mIn = 1'b0;
  bit   expectCont = 1'b0;

  function automatic logic [66:0] outs();
    return {outvld, outSopA, outEopA, outDataA};
  endfunction

  task automatic check(string nm, logic [66:0] act, logic [66:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Packet-level reference: a sop opens a fresh packet, eop releases it whole.
  task automatic modelWord(logic [63:0] d, logic s, logic e);
    if (s) begin
      cur.delete();
      cur.push_back('{s: 1'b1, e: e, d: d});
      mIn = !e;
      if (e) expQ.push_back(cur[0]);
    end else if (mIn) begin
      cur.push_back('{s: 1'b0, e: e, d: d});
      if (e) begin
        foreach (cur[i]) expQ.push_back(cur[i]);
        mIn = 1'b0;
      end
    end
  endtask

  task automatic sendWord(logic [63:0] d, logic s, logic e);
    @(negedge clk);
    inDataA = d;
    inSopA  = s;
    inEopA  = e;
    vld     = 1'b1;
    if (modelOn) modelWord(d, s, e);
  endtask

  task automatic idleCycle();
    @(negedge clk);
    vld     = 1'b0;
    inSopA  = 1'($urandom_range(0, 1));
    inEopA  = 1'($urandom_range(0, 1));
    inDataA = {32'($urandom), 32'($urandom)};
  endtask

  task automatic sendPkt(logic [63:0] base, int len);
    for (int i = 0; i < len; i++) sendWord(base + 64'(i), i == 0, i == len - 1);
  endtask

  task automatic expPkt(logic [63:0] base, int len);
    for (int i = 0; i < len; i++) expQ.push_back('{s: (i == 0), e: (i == len - 1), d: base + 64'(i)});
  endtask

  task automatic drain(string nm);
    int n;
    n = 0;
    @(negedge clk);
    vld = 1'b0; inSopA = 1'b0; inEopA = 1'b0;
    while ((expQ.size() != 0 || outvld) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check(nm, 67'(expQ.size()), 67'd0);
  endtask

  task automatic randomPhase();
    int len;
    int kind;
    logic [63:0] b;
    modelOn = 1'b1;
    for (int p = 0; p < 80; p++) begin
      len  = $urandom_range(1, 24);
      kind = $urandom_range(0, 7);
      b    = {32'($urandom), 32'($urandom)};
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idleCycle();
        sendWord(b + 64'(i), i == 0, (i == len - 1) && (kind != 0));
      end
      if (kind == 1) begin
        for (int j = 0; j < 2; j++) sendWord({32'($urandom), 32'($urandom)}, 1'b0, 1'($urandom_range(0, 1)));
      end
    end
    modelOn = 1'b0;
    drain("random_stream");
  endtask

  // Output monitor: every valid word must match the expected stream in order.
  always @(negedge clk) begin
    if (monOn) begin
      if (outvld) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("FAIL unexpected_out: got %h expected no output", outs());
        end else begin
          monExp = expQ.pop_front();
          check("out_word", outs(), {1'b1, monExp.s, monExp.e, monExp.d});
        end
        expectCont = !outEopA;
      end else begin
        check("idle_zero", outs(), 67'd0);
        if (expectCont) check("no_gap", {66'd0, outvld}, 67'd1);
        expectCont = 1'b0;
      end
    end
  end

  initial begin
    int  n;
    bit  sawVld;
    resetN = 1'b1; vld = 1'b0; inSopA = 1'b0; inEopA = 1'b0; inDataA = 64'd0;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 64'h1111_0000_0000_0000, 67'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 64'h2222_0000_0000_0001, 67'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 64'h3333_0000_0000_0002, 67'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 64'h4444_0000_0000_0003, 67'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 64'd0, {3'b110, 64'h1111_0000_0000_0000}};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 64'd0, {3'b100, 64'h2222_0000_0000_0001}};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 64'd0, {3'b100, 64'h3333_0000_0000_0002}};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 64'd0, {3'b101, 64'h4444_0000_0000_0003}};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 64'd0, 67'd0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 64'hDEADBEEF_00000001, 67'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 64'd0, {3'b111, 64'hDEADBEEF_00000001}};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 64'd0, 67'd0};

    repeat (3) @(posedge clk);
    #1 check("reset_state", outs(), 67'd0);
    @(negedge clk) resetN = 1'b0;
    @(posedge clk);
    #1 check("post_reset", outs(), 67'd0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      vld = tbl[i].v; inSopA = tbl[i].s; inEopA = tbl[i].e; inDataA = tbl[i].d;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    @(negedge clk) vld = 1'b0;
    monOn = 1'b1;

    // Second sop aborts the first packet; only the restarted packet emerges.
`ifdef ETH_SW_STATS_EN
    dropBase = pkt_drop_cnt;
`endif
    expQ.push_back('{s: 1'b1, e: 1'b0, d: 64'hA1});
    expQ.push_back('{s: 1'b0, e: 1'b1, d: 64'hA2});
    sendWord(64'hA0, 1'b1, 1'b0);
    sendWord(64'hA1, 1'b1, 1'b0);
    sendWord(64'hA2, 1'b0, 1'b1);
    drain("sop_abort");
`ifdef ETH_SW_STATS_EN
    check("drop_cnt", 67'(pkt_drop_cnt - dropBase), 67'd1);
`endif

    sendPkt(64'hB000, 191);
    expPkt(64'hC000, 2);
    sendPkt(64'hC000, 2);
    drain("oversize");

    sendPkt(64'hE000, 70);
    expPkt(64'hF000, 8);
    sendPkt(64'hF000, 8);
    drain("fifo_full");

    expPkt(64'h5000, 5);
    expPkt(64'h6000, 3);
    sendPkt(64'h5000, 5);
    sendPkt(64'h6000, 3);
    drain("back_to_back");

    // Reset in the middle of an output packet discards everything buffered.
    monOn = 1'b0;
    sendPkt(64'h7000, 10);
    @(negedge clk) vld = 1'b0;
    n = 0;
    while (!outvld && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_saw_output", {66'd0, outvld}, 67'd1);
    @(negedge clk) resetN = 1'b1;
    @(posedge clk);
    #1 check("rst_mid_out", outs(), 67'd0);
    @(negedge clk) resetN = 1'b0;
    @(posedge clk);
    #1 check("rst_after", outs(), 67'd0);
    sawVld = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (outvld) sawVld = 1'b1;
    end
    check("rst_discard", {66'd0, sawVld}, 67'd0);
    expQ.delete();
    mIn = 1'b0;
    expectCont = 1'b0;
    monOn = 1'b1;
    expPkt(64'h8000, 4);
    sendPkt(64'h8000, 4);
    drain("after_reset");

    randomPhase();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/eth_switch.md
# eth_switch

Single-port Ethernet packet switch datapath that carries port A. It accepts 64-bit packet words framed by start-of-packet and end-of-packet pulses and checks the framing. Each packet is buffered store-and-forward in an on-chip FIFO, and only complete, well-formed packets are forwarded on the output port. Malformed, oversized and overflowing packets are dropped.

## Interface
- DATA_W, 64: data word width.
- FIFO_DEPTH, 64: buffer depth in words; power of two.
- MAX_PKT_WORDS, 190: longest legal packet in words (1518 B / 8).
- clk  in  1  single clock; all logic on rising edge.
- resetN  in  1  synchronous, active-high reset (asserted when 1).
- inDataA  in  DATA_W  input packet word.
- inSopA  in  1  first word of packet.
- inEopA  in  1  last word of packet.
- vld  in  1  input word valid; words are ignored when 0. There is no backpressure.
- outDataA  out  DATA_W  output word; 0 when outvld=0.
- outSopA  out  1  first output word; qualified by outvld.
- outEopA  out  1  last output word; qualified by outvld.
- outvld  out  1  output word valid.

## Operation
**Input FSM** (evaluated only on words with vld=1): states IDLE, PKT, DROP.
- IDLE:
  - sop word: start a packet; go to PKT.
  - sop+eop word: one-word packet; commit immediately.
  - non-sop word: discard.
- PKT:
  - Each word is written to the FIFO tagged {sop, eop}.
  - eop word: commit the packet; go to IDLE.
  - sop word: abort the current packet (roll back); the word starts a new packet.
  - Word count would exceed MAX_PKT_WORDS, or FIFO is full: roll back; go to DROP.
- DROP:
  - Discard words until eop (go to IDLE) or sop (start a new packet; go to PKT).

**Commit / rollback**
- Write pointer `wr_ptr`; committed pointer `cmt_ptr`.
- Commit: `cmt_ptr` <= `wr_ptr`+1 on the eop write.
- Rollback: `wr_ptr` <= `cmt_ptr`.
- Free space is FIFO_DEPTH minus (`wr_ptr` − `rd_ptr`). Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.

**Output engine**
- Reads a word whenever `rd_ptr` != `cmt_ptr`.
- Emits words back-to-back; a packet, once started, is never interrupted.

Simultaneous write, read and commit in one cycle are legal.

## Timing
- All outputs are registered; every output is 0 during reset and in the cycle after it.
- Reset clears all pointers and returns the FSM to IDLE.
- Reset asserted mid-packet discards all buffered and partial data.
- Latency, empty FIFO:
  - eop word sampled at edge k gives outSopA/outvld at edge k+1 (visible in cycle k+1).
  - The packet then streams one word per cycle.
- A one-word packet (sop+eop) in at edge k appears at edge k+1 with outSopA=outEopA=1.
- Consecutive committed packets stream with no idle cycle between them.
- vld=0 gaps inside an input packet are allowed; gaps never appear on the output.

## Configuration
- ETH_SW_STATS_EN defined: adds output ports pkt_in_cnt, pkt_out_cnt and pkt_drop_cnt.
  - Each is a 32-bit wrapping counter; all clear on reset.
  - pkt_in_cnt: counts sop words.
  - pkt_out_cnt: counts output eop words.
  - pkt_drop_cnt: counts rollbacks, plus every discarded non-sop word seen in IDLE.
- Not defined: no counter ports and no counter logic.

## Structure
- Package `eth_sw_pkg` holds:
  - typedef `eth_word_t` struct {data[63:0], sop, eop};
  - FSM state enum;
  - default constants (DATA_W, FIFO_DEPTH, MAX_PKT_WORDS).
- One sub-module, `eth_sw_fifo`: synchronous RAM FIFO of `eth_word_t` with commit and rollback inputs and pointer-based occupancy.
- The top level holds the input FSM and the output engine.

## Test plan
- 4-word packet D0..D3 (sop on D0, eop on D3), vld=1 throughout: same 4 words out, outSopA with D0 one cycle after eop in, outEopA with D3.
- Single word 0xDEADBEEF_00000001 with sop+eop: output 1 cycle later with outSopA=outEopA=outvld=1.
- 3-word packet with a second sop on word 2: the first packet is dropped and only the second packet is output (pkt_drop_cnt=1 with ETH_SW_STATS_EN).
- 191-word packet: no output; a following 2-word packet is output intact.
- 70-word legal packet with FIFO_DEPTH=64: dropped on full; the following 8-word packet passes.
- resetN=1 asserted mid-output: all outputs are 0 the next cycle, and a new packet after reset is forwarded normally.
